cu_car_sequencer: RTL



---
 rtl/cu_car_sequencer_if.sv | 31 +++
 rtl/cu_car_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/cu_car_sequencer_if.sv
// Control-unit sequencer bus: control word fields, IR fields and ALU flags
// in, microinstruction address and retirement status out.
interface cu_car_sequencer_if #(
    parameter int unsigned CAR_W = 7,
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       car_ctrl;
    logic             halt_bit;
    logic [7:0]       opcode;
    logic             ind_flag;
    logic             acc_gt_zero;
    logic             mf_flag;
    logic             stall;
    logic             resume;
    logic [CAR_W-1:0] car;
    logic             halted;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    // Upstream side: control memory, IR, ALU and memory controller.
    modport master (
        output car_ctrl, halt_bit, opcode, ind_flag, acc_gt_zero, mf_flag, stall, resume,
        input  car, halted, instr_done, instr_count
    );

    // Sequencer side.
    modport slave (
        input  car_ctrl, halt_bit, opcode, ind_flag, acc_gt_zero, mf_flag, stall, resume,
        output car, halted, instr_done, instr_count
    );
endinterface

// File: rtl/cu_car_sequencer.sv
// Control Address Register sequencer for the microprogrammed control unit.
// Computes the next microinstruction address each cycle, handles HALT/resume,
// memory stalls and counts retired instructions.
// Optional feature macro: CU_STOREH_EN enables the STORE WB -> STOREH redirect
// when the multiply-overflow flag is set.
module cu_car_sequencer #(
    parameter int unsigned CAR_W = 7,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    cu_car_sequencer_if.slave bus
);
    typedef enum logic [0:0] {StRun, StHalted} state_e;

    localparam logic [CAR_W-1:0] CarFetch   = CAR_W'('h00);
    localparam logic [CAR_W-1:0] CarFo      = CAR_W'('h04);
    localparam logic [CAR_W-1:0] CarInd1    = CAR_W'('h05);
    localparam logic [CAR_W-1:0] CarStoreWb = CAR_W'('h08);
    localparam logic [CAR_W-1:0] CarStoreh  = CAR_W'('h21);

    state_e           state_q;
    logic [CAR_W-1:0] car_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic             storeh_redirect;

    // Opcode to first execute microstep; unknown opcodes run the NOP routine.
    function automatic logic [CAR_W-1:0] dispatch(input logic [7:0] op, input logic gt);
        case (op)
            8'h01:   return CAR_W'('h07);
            8'h02:   return CAR_W'('h09);
            8'h03:   return CAR_W'('h0B);
            8'h04:   return CAR_W'('h0D);
            8'h05:   return gt ? CAR_W'('h11) : CAR_W'('h1F);
            8'h06:   return CAR_W'('h11);
            8'h07:   return CAR_W'('h13);
            8'h08:   return CAR_W'('h0F);
            8'h0A:   return CAR_W'('h15);
            8'h0B:   return CAR_W'('h17);
            8'h0C:   return CAR_W'('h19);
            8'h0D:   return CAR_W'('h1B);
            8'h0E:   return CAR_W'('h1D);
            default: return CAR_W'('h1F);
        endcase
    endfunction

`ifdef CU_STOREH_EN
    // STORE writes the high product half too when the last MPY overflowed.
    assign storeh_redirect = (car_q == CarStoreWb) && bus.mf_flag;
`else
    logic unused_mf_flag;
    assign unused_mf_flag  = bus.mf_flag;
    assign storeh_redirect = 1'b0;
`endif

    // Sequencer state: address, run/halt, retirement pulse and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            car_q   <= CarFetch;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StHalted: begin
                    car_q <= CarFetch;
                    if (bus.resume) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!bus.stall) begin
                        if (bus.halt_bit) begin
                            car_q   <= CarFetch;
                            state_q <= StHalted;
                            done_q  <= 1'b1;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            unique case (bus.car_ctrl)
                                2'b00: car_q <= car_q;
                                2'b01: begin
                                    if (car_q == CarFo && bus.ind_flag) begin
                                        car_q <= CarInd1;
                                    end else begin
                                        car_q <= dispatch(bus.opcode, bus.acc_gt_zero);
                                    end
                                end
                                2'b10: car_q <= car_q + CAR_W'(1);
                                2'b11: begin
                                    if (storeh_redirect) begin
                                        car_q <= CarStoreh;
                                    end else begin
                                        car_q   <= CarFetch;
                                        done_q  <= 1'b1;
                                        count_q <= count_q + CNT_W'(1);
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.car         = car_q;
    assign bus.halted      = (state_q == StHalted);
    assign bus.instr_done  = done_q;
    assign bus.instr_count = count_q;
endmodule
